rvvi_tx_arbiter: RTL and testbench

RVVI_TX_ARBITER -- requirements
Module: rvvi_tx_arbiter

---
 rtl/cvw.sv | 15 +
 rtl/satcounter.sv | 32 +++
 rtl/rvvi_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rvvi_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvw.sv
// Shared types and constants for the RVVI transmit path.
package cvw;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrace = 2'd1,
    StCtrl  = 2'd2,
    StGap   = 2'd3
  } tx_state_e;

  // Idle cycles inserted after the last beat of every packet.
  localparam logic [31:0] DefaultPacketDelay = 32'd2;

endpackage

// File: rtl/satcounter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module satcounter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// Packet-level arbiter merging the RVVI trace stream and the control/heartbeat
// stream onto a single AXI-stream towards the Ethernet MAC. Packets are never
// interleaved; ties alternate, starting with control.
module rvvi_tx_arbiter
  import cvw::*;
#(
  parameter logic [31:0] PACKET_DELAY = DefaultPacketDelay,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Enable,
  input  logic [31:0]      TraceTdata,
  input  logic [3:0]       TraceTkeep,
  input  logic             TraceTvalid,
  input  logic             TraceTlast,
  output logic             TraceTready,
  input  logic [31:0]      CtrlTdata,
  input  logic [3:0]       CtrlTkeep,
  input  logic             CtrlTvalid,
  input  logic             CtrlTlast,
  output logic             CtrlTready,
  output logic [31:0]      TxTdata,
  output logic [3:0]       TxTkeep,
  output logic             TxTvalid,
  output logic             TxTlast,
  input  logic             TxTready,
  output logic             ExternalStall,
  output logic [CNT_W-1:0] TracePktCount,
  output logic [CNT_W-1:0] CtrlPktCount
);

  tx_state_e   state_q, state_d;
  logic        last_ctrl_q, last_ctrl_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;

  logic trace_done;
  logic ctrl_done;

  // Last beat of the granted packet accepted by the MAC this cycle.
  assign trace_done = (state_q == StTrace) && TraceTvalid && TxTready && TraceTlast;
  assign ctrl_done  = (state_q == StCtrl) && CtrlTvalid && TxTready && CtrlTlast;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant only from idle, hold until the last beat, then gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Enable) begin
          if (CtrlTvalid && (!TraceTvalid || !last_ctrl_q)) begin
            state_d = StCtrl;
          end else if (TraceTvalid) begin
            state_d = StTrace;
          end
        end
      end
      StTrace: begin
        if (trace_done) begin
          state_d = (PACKET_DELAY == 32'd0) ? StIdle : StGap;
        end
      end
      StCtrl: begin
        if (ctrl_done) begin
          state_d = (PACKET_DELAY == 32'd0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q <= 32'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: pass the granted source through, everything else quiet.
  always_comb begin
    TxTdata     = '0;
    TxTkeep     = '0;
    TxTvalid    = 1'b0;
    TxTlast     = 1'b0;
    TraceTready = 1'b0;
    CtrlTready  = 1'b0;
    unique case (state_q)
      StTrace: begin
        TxTdata     = TraceTdata;
        TxTkeep     = TraceTkeep;
        TxTvalid    = TraceTvalid;
        TxTlast     = TraceTlast;
        TraceTready = TxTready;
      end
      StCtrl: begin
        TxTdata    = CtrlTdata;
        TxTkeep    = CtrlTkeep;
        TxTvalid   = CtrlTvalid;
        TxTlast    = CtrlTlast;
        CtrlTready = TxTready;
      end
      default: begin
      end
    endcase
  end

  // Gap counter and tie-break flag next values.
  always_comb begin
    gap_cnt_d   = gap_cnt_q;
    last_ctrl_d = last_ctrl_q;
    if (trace_done || ctrl_done) begin
      gap_cnt_d = PACKET_DELAY;
    end else if ((state_q == StGap) && (gap_cnt_q != 32'd0)) begin
      gap_cnt_d = gap_cnt_q - 32'd1;
    end
    if (ctrl_done) begin
      last_ctrl_d = 1'b1;
    end else if (trace_done) begin
      last_ctrl_d = 1'b0;
    end
  end

  // Gap counter and tie-break flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap_cnt_q   <= '0;
      last_ctrl_q <= 1'b0;
    end else begin
      gap_cnt_q   <= gap_cnt_d;
      last_ctrl_q <= last_ctrl_d;
    end
  end

  // The core must stall whenever a trace beat is offered but not taken.
  assign ExternalStall = TraceTvalid & ~TraceTready;

  satcounter #(
    .Width (CNT_W)
  ) u_trace_cnt (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .inc_i   (trace_done),
    .count_o (TracePktCount)
  );

  satcounter #(
    .Width (CNT_W)
  ) u_ctrl_cnt (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .inc_i   (ctrl_done),
    .count_o (CtrlPktCount)
  );

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// Scoreboard bench for rvvi_tx_arbiter: expected Tx beats are queued as sources
// are driven and popped as the MAC side accepts them.
module tb_rvvi_tx_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] tr_data, ct_data, tx_data;
  logic [3:0]  tr_keep, ct_keep, tx_keep;
  logic        tr_valid, tr_last, tr_ready;
  logic        ct_valid, ct_last, ct_ready;
  logic        tx_valid, tx_last, tx_ready;
  logic        stall;
  logic [15:0] tr_cnt, ct_cnt;

  // Narrow-counter instance sharing the same stimulus.
  logic [31:0] s_tx_data;
  logic [3:0]  s_tx_keep;
  logic        s_tx_valid, s_tx_last, s_tr_ready, s_ct_ready, s_stall;
  logic [1:0]  s_tr_cnt, s_ct_cnt;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];
  int fw, fw_c, fw_c2, fw_t;

  always #5 clk = ~clk;

  rvvi_tx_arbiter #(
    .PACKET_DELAY (32'd2),
    .CNT_W        (16)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .Enable        (enable),
    .TraceTdata    (tr_data),
    .TraceTkeep    (tr_keep),
    .TraceTvalid   (tr_valid),
    .TraceTlast    (tr_last),
    .TraceTready   (tr_ready),
    .CtrlTdata     (ct_data),
    .CtrlTkeep     (ct_keep),
    .CtrlTvalid    (ct_valid),
    .CtrlTlast     (ct_last),
    .CtrlTready    (ct_ready),
    .TxTdata       (tx_data),
    .TxTkeep       (tx_keep),
    .TxTvalid      (tx_valid),
    .TxTlast       (tx_last),
    .TxTready      (tx_ready),
    .ExternalStall (stall),
    .TracePktCount (tr_cnt),
    .CtrlPktCount  (ct_cnt)
  );

  rvvi_tx_arbiter #(
    .PACKET_DELAY (32'd2),
    .CNT_W        (2)
  ) u_dut_sat (
    .clk           (clk),
    .resetn        (resetn),
    .Enable        (enable),
    .TraceTdata    (tr_data),
    .TraceTkeep    (tr_keep),
    .TraceTvalid   (tr_valid),
    .TraceTlast    (tr_last),
    .TraceTready   (s_tr_ready),
    .CtrlTdata     (ct_data),
    .CtrlTkeep     (ct_keep),
    .CtrlTvalid    (ct_valid),
    .CtrlTlast     (ct_last),
    .CtrlTready    (s_ct_ready),
    .TxTdata       (s_tx_data),
    .TxTkeep       (s_tx_keep),
    .TxTvalid      (s_tx_valid),
    .TxTlast       (s_tx_last),
    .TxTready      (tx_ready),
    .ExternalStall (s_stall),
    .TracePktCount (s_tr_cnt),
    .CtrlPktCount  (s_ct_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit is_ctrl, input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic l);
    if (is_ctrl) begin
      ct_valid = v; ct_data = d; ct_keep = k; ct_last = l;
    end else begin
      tr_valid = v; tr_data = d; tr_keep = k; tr_last = l;
    end
  endtask

  // Wait for the current beat to be accepted; reports non-accepting negedges.
  task automatic wait_acc(input bit is_ctrl, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited <= 300) begin
      @(negedge clk);
      if (is_ctrl ? (ct_valid && ct_ready) : (tr_valid && tr_ready)) acc = 1'b1;
      else waited++;
    end
    check_eq("beat accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_pkt(input bit is_ctrl, input int n, input logic [31:0] base,
                          input bit push, output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      d = base + 32'(i);
      k = 4'(i) ^ 4'hA;
      l = (i == n - 1);
      drive(is_ctrl, 1'b1, d, k, l);
      if (push) exp_q.push_back({d, k, l});
      wait_acc(is_ctrl, w);
      if (i == 0) first_wait = w;
      @(posedge clk); #1;
    end
    drive(is_ctrl, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    enable   = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst tx_valid", 64'(tx_valid), 64'd0);
    check_eq("rst trace_ready", 64'(tr_ready), 64'd0);
    check_eq("rst ctrl_ready", 64'(ct_ready), 64'd0);
    check_eq("rst trace_cnt", 64'(tr_cnt), 64'd0);
    check_eq("rst ctrl_cnt", 64'(ct_cnt), 64'd0);
    check_eq("rst sat_cnt", 64'(s_tr_cnt), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // MAC-side monitor: every accepted beat must match the scoreboard head,
  // and the bus must be all-zero whenever it is not valid.
  always @(negedge clk) begin
    if (resetn) begin
      if (tx_valid && tx_ready) begin
        check_eq("beat queued", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check_eq("tx beat", 64'({tx_data, tx_keep, tx_last}),
                                        64'(exp_q.pop_front()));
      end
      if (!tx_valid) check_eq("tx idle bus", 64'({tx_data, tx_keep, tx_last}), 64'd0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    enable = 1'b1;
    tx_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    #3;
    do_reset();

    // Trace-only 3-beat packet, then a back-to-back one across the gap.
    send_pkt(1'b0, 3, 32'h1000_0000, 1'b1, fw);
    check_eq("t1 grant wait", 64'(fw), 64'd1);
    check_eq("t1 trace_cnt", 64'(tr_cnt), 64'd1);
    check_eq("t1 gap tx_valid", 64'(tx_valid), 64'd0);
    send_pkt(1'b0, 2, 32'h1100_0000, 1'b1, fw);
    check_eq("t1 gap+idle wait", 64'(fw), 64'd3);
    check_eq("t1 trace_cnt2", 64'(tr_cnt), 64'd2);

    // Both sources from reset: ctrl, trace, ctrl.
    do_reset();
    for (int i = 0; i < 2; i++) exp_q.push_back({32'h2000_0000 + 32'(i), 4'(i) ^ 4'hA, i == 1});
    for (int i = 0; i < 2; i++) exp_q.push_back({32'h3000_0000 + 32'(i), 4'(i) ^ 4'hA, i == 1});
    for (int i = 0; i < 2; i++) exp_q.push_back({32'h2100_0000 + 32'(i), 4'(i) ^ 4'hA, i == 1});
    fork
      begin
        send_pkt(1'b1, 2, 32'h2000_0000, 1'b0, fw_c);
        send_pkt(1'b1, 2, 32'h2100_0000, 1'b0, fw_c2);
      end
      send_pkt(1'b0, 2, 32'h3000_0000, 1'b0, fw_t);
    join
    check_eq("t2 ctrl first wait", 64'(fw_c), 64'd1);
    check_eq("t2 trace wait", 64'(fw_t), 64'd6);
    check_eq("t2 ctrl second wait", 64'(fw_c2), 64'd8);
    check_eq("t2 ctrl_cnt", 64'(ct_cnt), 64'd2);
    check_eq("t2 trace_cnt", 64'(tr_cnt), 64'd1);

    // MAC backpressure toggling during a trace packet.
    idle_cycles(3);
    begin
      int idx;
      idx = 0;
      drive(1'b0, 1'b1, 32'h4000_0000, 4'h1, 1'b0);
      exp_q.push_back({32'h4000_0000, 4'h1, 1'b0});
      @(negedge clk);
      check_eq("t3 idle stall", 64'(stall), 64'd1);
      check_eq("t3 idle ready", 64'(tr_ready), 64'd0);
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
        tx_ready = (k % 2 == 0);
        @(negedge clk);
        check_eq("t3 trace ready", 64'(tr_ready), 64'(tx_ready));
        check_eq("t3 stall", 64'(stall), 64'(!tx_ready));
        @(posedge clk); #1;
        if (tx_ready) begin
          idx++;
          if (idx < 3) begin
            drive(1'b0, 1'b1, 32'h4000_0000 + 32'(idx), 4'(idx + 1), idx == 2);
            exp_q.push_back({32'h4000_0000 + 32'(idx), 4'(idx + 1), idx == 2});
          end else begin
            drive(1'b0, 1'b0, '0, '0, 1'b0);
          end
        end
      end
      tx_ready = 1'b1;
    end
    check_eq("t3 trace_cnt", 64'(tr_cnt), 64'd2);
    check_eq("t3 drained", 64'(exp_q.size()), 64'd0);

    // Enable drops on beat 2 of 4 with control pending.
    idle_cycles(3);
    fork
      send_pkt(1'b0, 4, 32'h5000_0000, 1'b1, fw);
      begin
        for (int c = 0; c < 50; c++) begin
          @(posedge clk); #2;
          if (tr_valid && tr_data == 32'h5000_0001) begin
            enable = 1'b0;
            drive(1'b1, 1'b1, 32'h6000_0000, 4'hA, 1'b1);
            break;
          end
        end
      end
    join
    check_eq("t4 trace_cnt", 64'(tr_cnt), 64'd3);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq("t4 hold ctrl_ready", 64'(ct_ready), 64'd0);
      check_eq("t4 hold tx_valid", 64'(tx_valid), 64'd0);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    send_pkt(1'b1, 1, 32'h6000_0000, 1'b1, fw);
    check_eq("t4 reenable wait", 64'(fw), 64'd1);
    check_eq("t4 ctrl_cnt", 64'(ct_cnt), 64'd3);

    // Reset pulse on beat 2 of a control packet.
    idle_cycles(3);
    drive(1'b1, 1'b1, 32'h7000_0000, 4'hA, 1'b0);
    exp_q.push_back({32'h7000_0000, 4'hA, 1'b0});
    wait_acc(1'b1, fw);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h7000_0001, 4'hB, 1'b0);
    #1;
    check_eq("t6 granted tx_valid", 64'(tx_valid), 64'd1);
    resetn = 1'b0;
    #1;
    check_eq("t6 rst tx_valid", 64'(tx_valid), 64'd0);
    check_eq("t6 rst ctrl_ready", 64'(ct_ready), 64'd0);
    check_eq("t6 rst ctrl_cnt", 64'(ct_cnt), 64'd0);
    check_eq("t6 rst trace_cnt", 64'(tr_cnt), 64'd0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("t6 post tx_valid", 64'(tx_valid), 64'd0);
    @(posedge clk); #1;
    send_pkt(1'b1, 1, 32'h7100_0000, 1'b1, fw);
    check_eq("t6 post grant wait", 64'(fw), 64'd1);
    check_eq("t6 post ctrl_cnt", 64'(ct_cnt), 64'd1);

    // Saturation of the 2-bit counter over five trace packets.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      send_pkt(1'b0, 1, 32'h8000_0000 + 32'(p << 4), 1'b1, fw);
      check_eq("t5 wait", 64'(fw), (p == 0) ? 64'd1 : 64'd3);
      check_eq("t5 wide cnt", 64'(tr_cnt), 64'(p + 1));
      check_eq("t5 sat cnt", 64'(s_tr_cnt), (p + 1 > 3) ? 64'd3 : 64'(p + 1));
    end

    idle_cycles(4);
    check_eq("final drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
